input_matrix_seq: RTL and testbench
===================================

INPUT_MATRIX_SEQ -- requirements
Module: input_matrix_seq

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 vtx_valid  in  1  upstream vertex present.
REQ-004 vtx_ready  out  1  block accepts vertex this cycle.
REQ-005 vtx_x, vtx_y, vtx_z  in  21 each, signed  vertex coordinates, Q10 fixed point (1.0 = 21'h000400).
REQ-006 vtx_w  in  21, signed  homogeneous W; present only when PERSP_W_EN is defined.
REQ-007 flush  in  1  issue a partial batch (fewer than 4 vertices).
REQ-008 mtx_valid  out  1  matrix available downstream.
REQ-009 mtx_ready  in  1  downstream consumes matrix.
REQ-010 mtx_data  out  336  packed 4x4 matrix of 21-bit elements.
REQ-011 mtx_cols  out  3  number of real vertices in mtx_data (1..4).
REQ-012 busy  out  1  high while in ISSUE or while the fill count is nonzero.

Function
REQ-013 The FSM SHALL have two states: FILL (count 0..3) and ISSUE.
REQ-014 In FILL: vtx_ready=1 and mtx_valid=0; a transfer (vtx_valid & vtx_ready) SHALL store the vertex into column[count] and increment count.
REQ-015 A transfer at count=3 SHALL move to ISSUE with mtx_cols=4; mtx_valid SHALL be high in the cycle after the transfer edge (1-cycle latency).
REQ-016 flush in FILL with count>0 and no transfer SHALL move to ISSUE with mtx_cols=count.
REQ-017 flush together with a transfer SHALL first store the vertex, then move to ISSUE with mtx_cols=count+1.
REQ-018 flush in FILL with count=0 and no transfer SHALL be ignored; flush in ISSUE SHALL be ignored.
REQ-019 Unfilled columns SHALL hold X=Y=Z=0, W=21'h000400.
REQ-020 Packing: column c (vertex c, c=0..3) SHALL occupy mtx_data[335-84c -: 84] as {X,Y,Z,W}, X in the top 21 bits; every column carries its own W, with no shared or duplicated element.
REQ-021 In ISSUE: vtx_ready=0, mtx_valid=1, and mtx_data/mtx_cols SHALL be held stable until mtx_ready.
REQ-022 mtx_valid & mtx_ready SHALL return the FSM to FILL with count=0 and all columns re-padded; the first new vertex is accepted the following cycle, with no same-cycle pass-through.
REQ-023 mtx_data SHALL be a registered output; no combinational path from vtx_* to mtx_*.
REQ-024 When PERSP_W_EN is not defined, W of filled columns SHALL be 21'h000400.

Reset
REQ-025 While rst_n=0: state=FILL, count=0, vtx_ready=0, mtx_valid=0, busy=0, mtx_cols=0, and all columns padded per REQ-019.
REQ-026 vtx_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-027 Reset mid-batch or during ISSUE SHALL discard the batch with no matrix issued.

Configuration
REQ-028 With PERSP_W_EN defined: the vtx_w port exists and its value is stored as W of each filled column.
REQ-029 Without PERSP_W_EN: the vtx_w port is absent and W is constant 21'h000400; padding W is 21'h000400 in both builds.

Verification
REQ-030 Four back-to-back vertices (1,2,3),(4,5,6),(7,8,9),(10,11,12) in Q10 with mtx_ready=1 -> one cycle of mtx_valid, mtx_cols=4, column 3 W=21'h000400, correct packing.
REQ-031 Two vertices, then flush -> mtx_cols=2; columns 2 and 3 are {0,0,0,21'h000400}.
REQ-032 Full batch with mtx_ready held low 10 cycles -> mtx_data stable, vtx_ready=0 throughout, FILL re-entered 1 cycle after mtx_ready.
REQ-033 flush on same edge as third vertex -> mtx_cols=3; flush at count=0 -> no mtx_valid.
REQ-034 rst_n pulsed low after 3 vertices -> mtx_valid stays 0; next 4 vertices form a clean batch.
REQ-035 PERSP_W_EN build, vtx_w=21'h000800 -> W fields of filled columns = 21'h000800, padded columns = 21'h000400.

Source files
------------

// File: rtl/input_matrix_seq.sv
// -----------------------------------------------------------------------------
// input_matrix_seq
//
// Gathers up to four homogeneous vertices into a packed 4x4 matrix of
// Q10 fixed-point elements (1.0 = 21'h000400) and hands the matrix downstream.
// Each vertex becomes one column {X,Y,Z,W}. Column c occupies
// mtx_data[335-84c -: 84], with X in the top 21 bits of the column.
// Columns that receive no vertex are padded with {0,0,0,1.0}.
//
// Two states:
//   FILL  : accept vertices (count 0..3); a 4th vertex or a flush issues.
//   ISSUE : matrix presented and held stable until mtx_ready.
//
// Optional feature (macro PERSP_W_EN):
//   defined   : vtx_w port exists and is stored as W of each filled column.
//   undefined : no vtx_w port; W of filled columns is 1.0 (21'h000400).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   vtx_valid  in   upstream vertex present
//   vtx_ready  out  vertex accepted this cycle (registered)
//   vtx_x/y/z  in   21-bit signed Q10 coordinates
//   vtx_w      in   21-bit signed Q10 W (PERSP_W_EN builds only)
//   flush      in   issue a partial batch
//   mtx_valid  out  matrix available (registered)
//   mtx_ready  in   downstream consumes matrix
//   mtx_data   out  336-bit packed matrix (registered)
//   mtx_cols   out  number of real vertices in mtx_data (1..4)
//   busy       out  high in ISSUE or while vertices are buffered
// -----------------------------------------------------------------------------
module input_matrix_seq (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vtx_valid,
  output logic               vtx_ready,
  input  logic signed [20:0] vtx_x,
  input  logic signed [20:0] vtx_y,
  input  logic signed [20:0] vtx_z,
`ifdef PERSP_W_EN
  input  logic signed [20:0] vtx_w,
`endif
  input  logic               flush,
  output logic               mtx_valid,
  input  logic               mtx_ready,
  output logic [335:0]       mtx_data,
  output logic [2:0]         mtx_cols,
  output logic               busy
);

  localparam logic [20:0] ONE_Q10 = 21'h000400;
  localparam logic [83:0] PAD_COL = {63'd0, ONE_Q10};

  typedef enum logic {FILL, ISSUE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [83:0] cols_q [4];
  logic [83:0] cols_d [4];
  logic [2:0]  mtx_cols_q, mtx_cols_d;
  logic        vtx_ready_q, vtx_ready_d;
  logic        mtx_valid_q, mtx_valid_d;
  logic        busy_q, busy_d;

  logic [20:0] w_in;
  logic [83:0] new_col;
  logic        xfer;

`ifdef PERSP_W_EN
  assign w_in = vtx_w;
`else
  assign w_in = ONE_Q10;
`endif

  assign new_col = {vtx_x, vtx_y, vtx_z, w_in};

  // Handshake qualifiers use the registered ready so nothing on vtx_*
  // reaches mtx_* without passing through a flop.
  assign xfer = (state_q == FILL) && vtx_valid && vtx_ready_q;

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mtx_cols_d = mtx_cols_q;
    for (int i = 0; i < 4; i++) cols_d[i] = cols_q[i];

    unique case (state_q)
      FILL: begin
        if (xfer) begin
          cols_d[count_q] = new_col;
          if (count_q == 2'd3 || flush) begin
            state_d    = ISSUE;
            mtx_cols_d = {1'b0, count_q} + 3'd1;
            count_d    = 2'd0;
          end else begin
            count_d = count_q + 2'd1;
          end
        end else if (flush && count_q != 2'd0) begin
          state_d    = ISSUE;
          mtx_cols_d = {1'b0, count_q};
          count_d    = 2'd0;
        end
      end
      ISSUE: begin
        // Leaving ISSUE re-pads every column so the next batch starts clean;
        // ready rises only after this edge, so no same-cycle pass-through.
        if (mtx_ready) begin
          state_d    = FILL;
          count_d    = 2'd0;
          mtx_cols_d = 3'd0;
          for (int i = 0; i < 4; i++) cols_d[i] = PAD_COL;
        end
      end
      default: state_d = FILL;
    endcase

    vtx_ready_d = (state_d == FILL);
    mtx_valid_d = (state_d == ISSUE);
    busy_d      = (state_d == ISSUE) || (count_d != 2'd0);
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // flop samples the values from before this edge.
  // NOTE: the column registers are reset too, because the padded matrix must
  // already be visible on mtx_data while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      count_q     <= 2'd0;
      mtx_cols_q  <= 3'd0;
      vtx_ready_q <= 1'b0;
      mtx_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 4; i++) cols_q[i] <= PAD_COL;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mtx_cols_q  <= mtx_cols_d;
      vtx_ready_q <= vtx_ready_d;
      mtx_valid_q <= mtx_valid_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 4; i++) cols_q[i] <= cols_d[i];
    end
  end

  assign vtx_ready = vtx_ready_q;
  assign mtx_valid = mtx_valid_q;
  assign mtx_cols  = mtx_cols_q;
  assign busy      = busy_q;
  assign mtx_data  = {cols_q[0], cols_q[1], cols_q[2], cols_q[3]};

endmodule

// File: tb/tb_input_matrix_seq.sv
// -----------------------------------------------------------------------------
// tb_input_matrix_seq
//
// Scoreboard bench for input_matrix_seq. A reference model (batch of vertices
// kept in a queue) observes inputs on the falling edge, decides which vertices
// the block accepts, and pushes the expected matrix when a batch completes or
// is flushed. An independent monitor compares every presented matrix against
// the head of the expected queue and pops it on the downstream handshake.
// Define PERSP_W_EN for both bench and RTL to exercise the W input.
// -----------------------------------------------------------------------------
module tb_input_matrix_seq;

  localparam logic [20:0]  ONE_Q10 = 21'h000400;
  localparam logic [83:0]  PAD_COL = {63'd0, ONE_Q10};
  localparam logic [335:0] PAD_ALL = {PAD_COL, PAD_COL, PAD_COL, PAD_COL};

  typedef struct {
    logic [20:0] x, y, z, w;
  } vtx_t;

  typedef struct {
    logic [335:0] data;
    logic [2:0]   cols;
  } mtx_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vtx_valid = 1'b0;
  logic               vtx_ready;
  logic signed [20:0] vtx_x = '0, vtx_y = '0, vtx_z = '0;
  logic signed [20:0] vtx_w = ONE_Q10;
  logic               flush = 1'b0;
  logic               mtx_valid;
  logic               mtx_ready = 1'b0;
  logic [335:0]       mtx_data;
  logic [2:0]         mtx_cols;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  vtx_t batch [$];
  mtx_t exp_q [$];
  logic issuing = 1'b0;
  logic rst_prev = 1'b1;

  always #5 clk = ~clk;

  input_matrix_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vtx_valid (vtx_valid),
    .vtx_ready (vtx_ready),
    .vtx_x     (vtx_x),
    .vtx_y     (vtx_y),
    .vtx_z     (vtx_z),
`ifdef PERSP_W_EN
    .vtx_w     (vtx_w),
`endif
    .flush     (flush),
    .mtx_valid (mtx_valid),
    .mtx_ready (mtx_ready),
    .mtx_data  (mtx_data),
    .mtx_cols  (mtx_cols),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [335:0] act, input logic [335:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic mtx_t build(input vtx_t v [$]);
    mtx_t m;
    m.data = '0;
    m.cols = 3'(v.size());
    for (int c = 0; c < 4; c++) begin
      if (c < v.size()) m.data[335-84*c -: 84] = {v[c].x, v[c].y, v[c].z, v[c].w};
      else              m.data[335-84*c -: 84] = PAD_COL;
    end
    return m;
  endfunction

  // Reference model: sees the inputs that the next rising edge will act on.
  always @(negedge clk) begin
    logic ready_exp;
    vtx_t v;
    if (!rst_n) begin
      batch.delete();
      exp_q.delete();
      issuing  = 1'b0;
      rst_prev = 1'b1;
      check("rst_vtx_ready", 336'(vtx_ready), 336'(1'b0));
      check("rst_mtx_valid", 336'(mtx_valid), 336'(1'b0));
      check("rst_busy",      336'(busy),      336'(1'b0));
      check("rst_mtx_cols",  336'(mtx_cols),  336'(3'd0));
      check("rst_mtx_data",  mtx_data,        PAD_ALL);
    end else begin
      ready_exp = !issuing && !rst_prev;
      rst_prev  = 1'b0;
      check("vtx_ready", 336'(vtx_ready), 336'(ready_exp));
      check("mtx_valid", 336'(mtx_valid), 336'(issuing));
      check("busy",      336'(busy),      336'(issuing || batch.size() > 0));
      if (issuing) begin
        if (mtx_ready) issuing = 1'b0;
      end else begin
        if (vtx_valid && ready_exp) begin
`ifdef PERSP_W_EN
          v.w = vtx_w;
`else
          v.w = ONE_Q10;
`endif
          v.x = vtx_x; v.y = vtx_y; v.z = vtx_z;
          batch.push_back(v);
        end
        if (batch.size() == 4 || (flush && batch.size() > 0)) begin
          exp_q.push_back(build(batch));
          batch.delete();
          issuing = 1'b1;
        end
      end
    end
  end

  // Monitor: compares every presented matrix, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && mtx_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_mtx_valid", 336'(mtx_valid), 336'(1'b0));
      end else begin
        check("mtx_data", mtx_data, exp_q[0].data);
        check("mtx_cols", 336'(mtx_cols), 336'(exp_q[0].cols));
        if (mtx_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [20:0] x, input logic [20:0] y,
                       input logic [20:0] z, input logic [20:0] w,
                       input logic fl, input logic mr);
    @(posedge clk);
    #1;
    vtx_valid = v; vtx_x = x; vtx_y = y; vtx_z = z; vtx_w = w;
    flush = fl; mtx_ready = mr;
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, ONE_Q10, 1'b0, mr);
  endtask

  // Vertex (k, k+1, k+2) in Q10 with the given W.
  task automatic q10_vtx(input int k, input logic [20:0] w, input logic fl, input logic mr);
    drive(1'b1, 21'(k << 10), 21'((k + 1) << 10), 21'((k + 2) << 10), w, fl, mr);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    vtx_valid = 1'b0; flush = 1'b0; mtx_ready = 1'b0;
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [20:0] w2;
`ifdef PERSP_W_EN
    w2 = 21'h000800;
`else
    w2 = ONE_Q10;
`endif
    // Reset state, held across several edges.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Four back-to-back vertices, downstream always ready.
    for (int i = 0; i < 4; i++) q10_vtx(3 * i + 1, w2, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Two vertices then flush -> two padded columns.
    q10_vtx(1, w2, 1'b0, 1'b1);
    q10_vtx(4, w2, 1'b0, 1'b1);
    drive(1'b0, '0, '0, '0, ONE_Q10, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Full batch held for 10 cycles; upstream keeps offering a vertex.
    for (int i = 0; i < 4; i++) q10_vtx(10 * i + 2, w2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) q10_vtx(99, w2, 1'b1, 1'b0);
    drive(1'b0, '0, '0, '0, ONE_Q10, 1'b0, 1'b1);
    q10_vtx(50, w2, 1'b0, 1'b1);
    drive(1'b0, '0, '0, '0, ONE_Q10, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Flush on the third vertex, then flush with an empty batch.
    q10_vtx(7, w2, 1'b0, 1'b1);
    q10_vtx(8, w2, 1'b0, 1'b1);
    q10_vtx(9, w2, 1'b1, 1'b1);
    idle(3, 1'b1);
    drive(1'b0, '0, '0, '0, ONE_Q10, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Reset after three vertices, then a clean batch.
    for (int i = 0; i < 3; i++) q10_vtx(i + 20, w2, 1'b0, 1'b1);
    do_reset(2);
    for (int i = 0; i < 4; i++) q10_vtx(i + 30, w2, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Reset while a matrix is being held.
    for (int i = 0; i < 4; i++) q10_vtx(i + 40, w2, 1'b0, 1'b0);
    idle(2, 1'b0);
    do_reset(1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [20:0] wr;
`ifdef PERSP_W_EN
      wr = 21'($urandom);
`else
      wr = ONE_Q10;
`endif
      drive(($urandom_range(0, 9) < 7), 21'($urandom), 21'($urandom), 21'($urandom), wr,
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 1) == 1));
    end

    // Drain: flush leftovers and accept everything.
    drive(1'b0, '0, '0, '0, ONE_Q10, 1'b1, 1'b1);
    idle(4, 1'b1);
    drive(1'b0, '0, '0, '0, ONE_Q10, 1'b1, 1'b1);
    idle(4, 1'b1);
    @(negedge clk);
    #1;
    check("drain_exp_q_empty", 336'(exp_q.size()), 336'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
